// File: rtl/cnn_settle_monitor.sv
// Settling monitor for a 4x4 CNN array: snapshots cell states per sweep, declares convergence or timeout.
// Optional macro CNN_DELTA_TOL_EN: cells match within +/-TOL instead of on exact equality.
module cnn_settle_monitor #(
    parameter int unsigned STABLE_SWEEPS = 2,
    parameter int unsigned MAX_SWEEPS    = 255,
    parameter int unsigned TOL           = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sweep_tick,
    input  logic signed [8:0] Y1_in,
    input  logic signed [8:0] Y2_in,
    input  logic signed [8:0] Y3_in,
    input  logic signed [8:0] Y4_in,
    input  logic signed [8:0] Y5_in,
    input  logic signed [8:0] Y6_in,
    input  logic signed [8:0] Y7_in,
    input  logic signed [8:0] Y8_in,
    input  logic signed [8:0] Y9_in,
    input  logic signed [8:0] Y10_in,
    input  logic signed [8:0] Y11_in,
    input  logic signed [8:0] Y12_in,
    input  logic signed [8:0] Y13_in,
    input  logic signed [8:0] Y14_in,
    input  logic signed [8:0] Y15_in,
    input  logic signed [8:0] Y16_in,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [15:0]       bin_out,
    output logic              converged,
    output logic              timeout,
    output logic [7:0]        sweep_count,
    output logic              busy
);

    localparam int unsigned NCELL = 16;
    localparam int unsigned DW    = 9;
    localparam int unsigned CW    = 10;
    localparam int unsigned SW    = 4;
    localparam int unsigned NW    = 8;

`ifdef CNN_DELTA_TOL_EN
    localparam int unsigned MATCH_TOL = TOL;
`else
    localparam int unsigned MATCH_TOL = 0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [DW-1:0]   y_c  [NCELL];
    logic [DW-1:0]   snap [NCELL];
    logic            snap_valid;
    logic [SW-1:0]   stable_cnt;

    logic            all_match_c;
    logic [SW-1:0]   stable_next_c;
    logic [NW-1:0]   count_next_c;
    logic            hit_stable_c;
    logic            hit_max_c;
    logic [NCELL-1:0] bin_c;

    assign y_c[0]  = Y1_in;
    assign y_c[1]  = Y2_in;
    assign y_c[2]  = Y3_in;
    assign y_c[3]  = Y4_in;
    assign y_c[4]  = Y5_in;
    assign y_c[5]  = Y6_in;
    assign y_c[6]  = Y7_in;
    assign y_c[7]  = Y8_in;
    assign y_c[8]  = Y9_in;
    assign y_c[9]  = Y10_in;
    assign y_c[10] = Y11_in;
    assign y_c[11] = Y12_in;
    assign y_c[12] = Y13_in;
    assign y_c[13] = Y14_in;
    assign y_c[14] = Y15_in;
    assign y_c[15] = Y16_in;

    // Cellwise delta against the previous snapshot, sign-extended so -256 -> 255 cannot wrap.
    always_comb begin
        logic [CW-1:0] diff;
        logic [CW-1:0] mag;
        diff          = '0;
        mag           = '0;
        all_match_c   = 1'b1;
        bin_c         = '0;
        for (int unsigned i = 0; i < NCELL; i++) begin
            diff = {y_c[i][DW-1], y_c[i]} - {snap[i][DW-1], snap[i]};
            mag  = diff[CW-1] ? (~diff + CW'(1)) : diff;
            if (mag > CW'(MATCH_TOL)) begin
                all_match_c = 1'b0;
            end
            bin_c[i] = ~y_c[i][DW-1];
        end
        if (snap_valid && all_match_c) begin
            stable_next_c = (stable_cnt == {SW{1'b1}}) ? stable_cnt : stable_cnt + SW'(1);
        end else begin
            stable_next_c = '0;
        end
        count_next_c = (sweep_count == {NW{1'b1}}) ? sweep_count : sweep_count + NW'(1);
        hit_stable_c = 32'(stable_next_c) >= STABLE_SWEEPS;
        hit_max_c    = 32'(count_next_c) >= MAX_SWEEPS;
    end

    // Control FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            converged   <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b0;
            bin_out     <= '0;
            sweep_count <= '0;
            stable_cnt  <= '0;
            snap_valid  <= 1'b0;
            for (int unsigned i = 0; i < NCELL; i++) begin
                snap[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sweep_count <= '0;
                        stable_cnt  <= '0;
                        snap_valid  <= 1'b0;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (sweep_tick) begin
                        for (int unsigned i = 0; i < NCELL; i++) begin
                            snap[i] <= y_c[i];
                        end
                        snap_valid  <= 1'b1;
                        sweep_count <= count_next_c;
                        stable_cnt  <= stable_next_c;
                        if (hit_stable_c || hit_max_c) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                            converged <= hit_stable_c;
                            timeout   <= ~hit_stable_c;
                            bin_out   <= bin_c;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        converged <= 1'b0;
                        timeout   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_settle_monitor.sv
// Randomized self-checking bench for cnn_settle_monitor against a sweep-level reference model.
module tb_cnn_settle_monitor;

    localparam int STABLE = 2;
    localparam int MAXS   = 8;
`ifdef CNN_DELTA_TOL_EN
    localparam int TB_TOL = 1;
`else
    localparam int TB_TOL = 0;
`endif

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              sweep_tick;
    logic signed [8:0] y [16];
    logic              out_ready;
    logic              out_valid;
    logic [15:0]       bin_out;
    logic              converged;
    logic              timeout;
    logic [7:0]        sweep_count;
    logic              busy;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: one entry per sweep, plain integer arithmetic.
    int          m_prev [16];
    bit          m_have;
    int          m_stable;
    int          m_count;
    bit          m_done;
    bit          m_conv;
    bit          m_tmo;
    logic [15:0] m_bin;

    cnn_settle_monitor #(.STABLE_SWEEPS(STABLE), .MAX_SWEEPS(MAXS), .TOL(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sweep_tick(sweep_tick),
        .Y1_in(y[0]), .Y2_in(y[1]), .Y3_in(y[2]), .Y4_in(y[3]),
        .Y5_in(y[4]), .Y6_in(y[5]), .Y7_in(y[6]), .Y8_in(y[7]),
        .Y9_in(y[8]), .Y10_in(y[9]), .Y11_in(y[10]), .Y12_in(y[11]),
        .Y13_in(y[12]), .Y14_in(y[13]), .Y15_in(y[14]), .Y16_in(y[15]),
        .out_ready(out_ready), .out_valid(out_valid), .bin_out(bin_out),
        .converged(converged), .timeout(timeout), .sweep_count(sweep_count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, want completion");
        $fatal(1);
    end

    task automatic model_start();
        m_have   = 1'b0;
        m_stable = 0;
        m_count  = 0;
        m_done   = 1'b0;
        m_conv   = 1'b0;
        m_tmo    = 1'b0;
    endtask

    task automatic model_tick();
        bit same;
        int d;
        same = m_have;
        for (int i = 0; i < 16; i++) begin
            d = int'(y[i]) - m_prev[i];
            if (d < 0) d = -d;
            if (d > TB_TOL) same = 1'b0;
            m_prev[i] = int'(y[i]);
            m_bin[i]  = (int'(y[i]) >= 0);
        end
        m_have   = 1'b1;
        m_stable = same ? m_stable + 1 : 0;
        if (m_count < 255) m_count++;
        if (m_stable >= STABLE) begin
            m_done = 1'b1; m_conv = 1'b1; m_tmo = 1'b0;
        end else if (m_count >= MAXS) begin
            m_done = 1'b1; m_conv = 1'b0; m_tmo = 1'b1;
        end
    endtask

    // Sweep vector generators for the directed and random scenarios.
    task automatic fill_vec(input int mode, input int k);
        for (int i = 0; i < 16; i++) begin
            case (mode)
                0: y[i] = 9'sd100;
                1: y[i] = -9'sd20;
                2: y[i] = 9'sd33;
                3: y[i] = 9'sd7;
                5: y[i] = -9'sd1;
                default: if (k == 0 || $urandom_range(1, 0) == 1) y[i] = 9'($urandom);
            endcase
        end
        if (mode == 4 && k != 0 && $urandom_range(1, 0) == 1) begin
            for (int i = 0; i < 16; i++) y[i] = 9'(m_prev[i]);
        end
        if (mode == 1) y[0]  = (k % 2 == 0) ? 9'sd5 : -9'sd5;
        if (mode == 2) y[6]  = (k % 2 == 0) ? 9'sd10 : 9'sd11;
        if (mode == 3) y[2]  = (k == 0) ? -9'sd256 : 9'sd255;
    endtask

    task automatic drive_tick();
        sweep_tick = 1'b1;
        model_tick();
        @(negedge clk);
        sweep_tick = 1'b0;
    endtask

    task automatic start_run(input string name);
        @(negedge clk);
        start = 1'b1;
        model_start();
        @(negedge clk);
        start = 1'b0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL %s busy after start: got %0b want 1", name, busy);
        else n_pass++;
        n_total++;
        if (sweep_count !== 8'd0) $display("FAIL %s count after start: got %0d want 0", name, sweep_count);
        else n_pass++;
    endtask

    task automatic run_until_done(input int mode, input string name);
        int k;
        for (k = 0; !m_done && k < 300; k++) begin
            fill_vec(mode, k);
            drive_tick();
            if (!m_done) begin
                n_total++;
                if (out_valid !== 1'b0 || sweep_count !== 8'(m_count))
                    $display("FAIL %s sweep %0d: got valid=%0b count=%0d want valid=0 count=%0d",
                             name, k, out_valid, sweep_count, m_count);
                else n_pass++;
            end
        end
        n_total++;
        if (!m_done) $display("FAIL %s bound: got no completion in %0d sweeps want completion", name, k);
        else n_pass++;
        n_total++;
        if (out_valid !== 1'b1 || busy !== 1'b0 || converged !== m_conv || timeout !== m_tmo)
            $display("FAIL %s status: got v=%0b b=%0b c=%0b t=%0b want v=1 b=0 c=%0b t=%0b",
                     name, out_valid, busy, converged, timeout, m_conv, m_tmo);
        else n_pass++;
        n_total++;
        if (sweep_count !== 8'(m_count) || bin_out !== m_bin)
            $display("FAIL %s result: got count=%0d bin=%h want count=%0d bin=%h",
                     name, sweep_count, bin_out, m_count, m_bin);
        else n_pass++;
    endtask

    task automatic finish_run(input string name, input int wait_cycles);
        for (int i = 0; i < wait_cycles; i++) begin
            @(negedge clk);
            n_total++;
            if (out_valid !== 1'b1) $display("FAIL %s valid held: got %0b want 1", name, out_valid);
            else n_pass++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || converged !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s release: got v=%0b c=%0b t=%0b b=%0b want all 0",
                     name, out_valid, converged, timeout, busy);
        else n_pass++;
        n_total++;
        if (bin_out !== m_bin || sweep_count !== 8'(m_count))
            $display("FAIL %s release hold: got bin=%h count=%0d want bin=%h count=%0d",
                     name, bin_out, sweep_count, m_bin, m_count);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sweep_tick = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 16; i++) y[i] = '0;
        m_bin = '0; m_count = 0;
        repeat (3) @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0 || converged !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0 ||
            bin_out !== 16'h0 || sweep_count !== 8'd0)
            $display("FAIL reset outputs: got v=%0b c=%0b t=%0b b=%0b bin=%h n=%0d want all 0",
                     out_valid, converged, timeout, busy, bin_out, sweep_count);
        else n_pass++;
        rst_n = 1'b1;
        sweep_tick = 1'b1;
        repeat (3) @(negedge clk);
        sweep_tick = 1'b0;
        n_total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || sweep_count !== 8'd0)
            $display("FAIL reset idle wait: got b=%0b v=%0b n=%0d want 0 0 0", busy, out_valid, sweep_count);
        else n_pass++;
    endtask

    task automatic test_converge();
        start_run("converge");
        run_until_done(0, "converge");
        n_total++;
        if (sweep_count !== 8'd3 || bin_out !== 16'hFFFF || converged !== 1'b1)
            $display("FAIL converge fixed: got n=%0d bin=%h c=%0b want n=3 bin=ffff c=1",
                     sweep_count, bin_out, converged);
        else n_pass++;
        finish_run("converge", 0);
    endtask

    task automatic test_timeout();
        start_run("timeout");
        run_until_done(1, "timeout");
        n_total++;
        if (timeout !== 1'b1 || sweep_count !== 8'(MAXS) || bin_out !== 16'h0000)
            $display("FAIL timeout fixed: got t=%0b n=%0d bin=%h want t=1 n=%0d bin=0000",
                     timeout, sweep_count, bin_out, MAXS);
        else n_pass++;
        finish_run("timeout", 2);
    endtask

    task automatic test_hold();
        start_run("hold");
        run_until_done(0, "hold");
        for (int c = 0; c < 10; c++) begin
            start      = 1'($urandom);
            sweep_tick = 1'($urandom);
            for (int i = 0; i < 16; i++) y[i] = 9'($urandom);
            @(negedge clk);
            n_total++;
            if (out_valid !== 1'b1 || converged !== m_conv || timeout !== m_tmo || busy !== 1'b0 ||
                bin_out !== m_bin || sweep_count !== 8'(m_count))
                $display("FAIL hold cycle %0d: got v=%0b c=%0b t=%0b bin=%h n=%0d want v=1 c=%0b t=%0b bin=%h n=%0d",
                         c, out_valid, converged, timeout, bin_out, sweep_count,
                         m_conv, m_tmo, m_bin, m_count);
            else n_pass++;
        end
        start = 1'b0;
        sweep_tick = 1'b0;
        finish_run("hold", 0);
    endtask

    task automatic test_reset_mid_run();
        start_run("midreset");
        fill_vec(4, 0); drive_tick();
        fill_vec(4, 1); drive_tick();
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || sweep_count !== 8'd0 || bin_out !== 16'h0 ||
            converged !== 1'b0 || timeout !== 1'b0)
            $display("FAIL midreset async clear: got v=%0b b=%0b n=%0d bin=%h c=%0b t=%0b want all 0",
                     out_valid, busy, sweep_count, bin_out, converged, timeout);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            sweep_tick = 1'b1;
            for (int i = 0; i < 16; i++) y[i] = 9'sd50;
            @(negedge clk);
            n_total++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || sweep_count !== 8'd0)
                $display("FAIL midreset idle %0d: got v=%0b b=%0b n=%0d want 0 0 0",
                         c, out_valid, busy, sweep_count);
            else n_pass++;
        end
        sweep_tick = 1'b0;
    endtask

    task automatic test_tol();
        start_run("tol");
        run_until_done(2, "tol");
        n_total++;
`ifdef CNN_DELTA_TOL_EN
        if (converged !== 1'b1 || sweep_count !== 8'd3)
            $display("FAIL tol window: got c=%0b n=%0d want c=1 n=3", converged, sweep_count);
`else
        if (timeout !== 1'b1 || sweep_count !== 8'(MAXS))
            $display("FAIL tol exact: got t=%0b n=%0d want t=1 n=%0d", timeout, sweep_count, MAXS);
`endif
        else n_pass++;
        finish_run("tol", 1);
    endtask

    task automatic test_wrap();
        start_run("wrap");
        run_until_done(3, "wrap");
        n_total++;
        if (converged !== 1'b1 || sweep_count !== 8'd4 || bin_out !== 16'hFFFF)
            $display("FAIL wrap: got c=%0b n=%0d bin=%h want c=1 n=4 bin=ffff", converged, sweep_count, bin_out);
        else n_pass++;
        finish_run("wrap", 0);
    endtask

    task automatic test_back_to_back();
        // start with a coincident tick in IDLE: that tick is ignored, the next one is the first sweep.
        @(negedge clk);
        fill_vec(5, 0);
        start = 1'b1;
        sweep_tick = 1'b1;
        model_start();
        @(negedge clk);
        start = 1'b0;
        model_tick();
        @(negedge clk);
        sweep_tick = 1'b0;
        n_total++;
        if (sweep_count !== 8'(m_count) || busy !== 1'b1)
            $display("FAIL b2b entry tick: got n=%0d b=%0b want n=%0d b=1", sweep_count, busy, m_count);
        else n_pass++;
        run_until_done(5, "b2b");
        n_total++;
        if (sweep_count !== 8'd3 || bin_out !== 16'h0000)
            $display("FAIL b2b result: got n=%0d bin=%h want n=3 bin=0000", sweep_count, bin_out);
        else n_pass++;
        finish_run("b2b", 0);
        start_run("b2b second");
        run_until_done(0, "b2b second");
        finish_run("b2b second", 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 25; r++) begin
            start_run("random");
            run_until_done(4, "random");
            finish_run("random", int'($urandom_range(3, 0)));
        end
    endtask

    initial begin
        test_reset();
        test_converge();
        test_timeout();
        test_hold();
        test_reset_mid_run();
        test_tol();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
